l1_lru_stack_feeder: RTL and testbench

L1_LRU_STACK_FEEDER -- requirements
Module: l1_lru_stack_feeder

---
 rtl/l1_lru_stack_feeder_pkg.sv | 18 +
 rtl/lru_stack_search.sv | 25 ++
 rtl/l1_lru_stack_feeder.sv | 130 +++++++++++++
 tb/tb_l1_lru_stack_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1_lru_stack_feeder_pkg.sv
// Shared constants and FSM encoding for the L1 LRU stack feeder and the L2 subset stage.
package l1_lru_stack_feeder_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFF_W    = 4;
  localparam int unsigned L1_WAY   = 16;
  localparam int unsigned L1_IDX_W = 10;
  localparam int unsigned CNT_W    = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_UPD = 3'd3,
    ST_WAIT_CLR = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/lru_stack_search.sv
// Parallel tag compare across one LRU stack; the lowest matching position wins.
module lru_stack_search #(
  parameter int unsigned WAY   = 16,
  parameter int unsigned TAG_W = 18,
  localparam int unsigned POS_W = $clog2(WAY)
) (
  input  logic [WAY-1:0][TAG_W-1:0] tags,
  input  logic [WAY-1:0]            valid,
  input  logic [TAG_W-1:0]          key,
  output logic                      hit_c,
  output logic [POS_W-1:0]          pos_c
);

  always_comb begin
    hit_c = 1'b0;
    pos_c = '0;
    for (int unsigned i = 0; i < WAY; i++) begin
      if (!hit_c && valid[POS_W'(i)] && (tags[POS_W'(i)] == key)) begin
        hit_c = 1'b1;
        pos_c = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/l1_lru_stack_feeder.sv
// Per-set LRU stack of L1 tags: reports stack distance of each trace address and
// hands the set index and distance to the L2 subset stage with a start pulse.
module l1_lru_stack_feeder
  import l1_lru_stack_feeder_pkg::*;
#(
  parameter int unsigned WAY   = L1_WAY,
  parameter int unsigned IDX_W = L1_IDX_W,
  parameter int unsigned TAG_W = ADDR_W - OFF_W - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  find_start,
  output logic [IDX_W-1:0]      msb_index,
  output logic [$clog2(WAY):0]  hit_way,
  input  logic                  updated,
  output logic [CNT_W-1:0]      l1_hit_count,
  output logic [CNT_W-1:0]      l1_miss_count
);

  localparam int unsigned POS_W = $clog2(WAY);
  localparam int unsigned HW_W  = POS_W + 1;
  localparam int unsigned SETS  = 1 << IDX_W;

  feeder_state_e state_q, state_d;

  logic [TAG_W-1:0]            tag_q;
  logic [WAY-1:0][TAG_W-1:0]   tag_mem   [SETS];
  logic [WAY-1:0]              valid_mem [SETS];
  logic [WAY-1:0][TAG_W-1:0]   rd_tags, mtf_tags;
  logic [WAY-1:0]              rd_valid, mtf_valid;
  logic                        srch_hit_c;
  logic [POS_W-1:0]            srch_pos_c;
  logic                        accept_c;
  logic                        unused_offset;

  assign accept_c      = (state_q == ST_IDLE) && req_valid;
  assign rd_tags       = tag_mem[msb_index];
  assign rd_valid      = valid_mem[msb_index];
  assign unused_offset = ^addr[OFF_W-1:0];

  lru_stack_search #(
    .WAY   (WAY),
    .TAG_W (TAG_W)
  ) u_search (
    .tags  (rd_tags),
    .valid (rd_valid),
    .key   (tag_q),
    .hit_c (srch_hit_c),
    .pos_c (srch_pos_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; updated is only honoured in the two wait states
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP:   state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT_UPD;
      ST_WAIT_UPD: if (updated)   state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!updated)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Move-to-front image of the selected set; hit_way==WAY (msb set) means miss
  always_comb begin
    mtf_tags  = rd_tags;
    mtf_valid = rd_valid;
    for (int unsigned i = 1; i < WAY; i++) begin
      if (hit_way[POS_W] || (POS_W'(i) <= hit_way[POS_W-1:0])) begin
        mtf_tags[POS_W'(i)]  = rd_tags[POS_W'(i - 1)];
        mtf_valid[POS_W'(i)] = rd_valid[POS_W'(i - 1)];
      end
    end
    mtf_tags[0]  = tag_q;
    mtf_valid[0] = 1'b1;
  end

  // Tag storage carries no reset; only the valid bits are cleared
  always_ff @(posedge clk) begin
    if (state_q == ST_ISSUE) tag_mem[msb_index] <= mtf_tags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) valid_mem[IDX_W'(s)] <= '0;
    end else if (state_q == ST_ISSUE) begin
      valid_mem[msb_index] <= mtf_valid;
    end
  end

  // Registered outputs, request latch and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b1;
      find_start    <= 1'b0;
      msb_index     <= '0;
      tag_q         <= '0;
      hit_way       <= '0;
      l1_hit_count  <= '0;
      l1_miss_count <= '0;
    end else begin
      req_ready  <= (state_d == ST_IDLE);
      find_start <= (state_d == ST_ISSUE);
      if (accept_c) begin
        msb_index <= addr[OFF_W +: IDX_W];
        tag_q     <= addr[OFF_W + IDX_W +: TAG_W];
      end
      if (state_q == ST_LOOKUP) begin
        if (srch_hit_c) begin
          hit_way      <= {1'b0, srch_pos_c};
          l1_hit_count <= l1_hit_count + CNT_W'(1);
        end else begin
          hit_way       <= HW_W'(WAY);
          l1_miss_count <= l1_miss_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_l1_lru_stack_feeder.sv
// Directed bench for l1_lru_stack_feeder: list-based LRU model plus per-cycle output compare.
module tb_l1_lru_stack_feeder;

  localparam int WAY   = 16;
  localparam int IDX_W = 10;
  localparam int TAG_W = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        find_start;
  logic [9:0]  msb_index;
  logic [4:0]  hit_way;
  logic        updated;
  logic [19:0] l1_hit_count;
  logic [19:0] l1_miss_count;

  always #5 clk = ~clk;

  l1_lru_stack_feeder #(.WAY(WAY), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .addr          (addr),
    .find_start    (find_start),
    .msb_index     (msb_index),
    .hit_way       (hit_way),
    .updated       (updated),
    .l1_hit_count  (l1_hit_count),
    .l1_miss_count (l1_miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fs_cnt  = 0;

  // Expected output values, advanced by the driver at each clock edge
  logic        exp_ready, exp_find;
  logic [4:0]  exp_hw;
  logic [9:0]  exp_msb;
  logic [19:0] exp_hits, exp_miss;

  // Model: per set an ordered list of tags, most recent first
  logic [17:0] mtag [1024][16];
  int          mlen [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (find_start === 1'b1) fs_cnt++;
      check("req_ready",  32'(req_ready),     32'(exp_ready));
      check("find_start", 32'(find_start),    32'(exp_find));
      check("hit_way",    32'(hit_way),       32'(exp_hw));
      check("msb_index",  32'(msb_index),     32'(exp_msb));
      check("hit_count",  32'(l1_hit_count),  32'(exp_hits));
      check("miss_count", 32'(l1_miss_count), 32'(exp_miss));
    end
  endtask

  function automatic int model_find(input int s, input logic [17:0] t);
    for (int i = 0; i < mlen[s]; i++)
      if (mtag[s][i] == t) return i;
    return WAY;
  endfunction

  // Remove the hit entry (or the oldest when full) and push the tag at the front
  function automatic void model_touch(input int s, input logic [17:0] t, input int d);
    int last;
    if (d < WAY) last = d;
    else         last = (mlen[s] < WAY) ? mlen[s] : WAY - 1;
    for (int i = last; i > 0; i--) mtag[s][i] = mtag[s][i-1];
    mtag[s][0] = t;
    if (d == WAY && mlen[s] < WAY) mlen[s]++;
  endfunction

  function automatic logic [31:0] mk(input int t, input int s);
    return {18'(t), 10'(s), 4'h0};
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 1024; s++) mlen[s] = 0;
    exp_ready = 1'b1; exp_find = 1'b0; exp_hw = '0; exp_msb = '0;
    exp_hits = '0; exp_miss = '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; delay = WAIT_UPD cycles before updated, hold = extra cycles updated stays high
  task automatic do_access(input logic [31:0] a, input int delay, input int hold,
                           input bit poke_valid, input bit early_upd, output logic [4:0] dut_hw);
    int s;
    int d;
    logic [17:0] t;
    s = int'(a[13:4]);
    t = a[31:14];
    d = model_find(s, t);
    req_valid = 1'b1;
    addr = a;
    step();
    req_valid = poke_valid;
    addr = $urandom;
    exp_ready = 1'b0;
    exp_msb = a[13:4];
    if (early_upd) updated = 1'b1;
    step();
    updated = 1'b0;
    exp_find = 1'b1;
    exp_hw = 5'(d);
    if (d < WAY) exp_hits++;
    else         exp_miss++;
    dut_hw = hit_way;
    model_touch(s, t, d);
    step();
    exp_find = 1'b0;
    repeat (delay) step();
    updated = 1'b1;
    step();
    repeat (hold) step();
    req_valid = 1'b0;
    updated = 1'b0;
    step();
    exp_ready = 1'b1;
  endtask

  initial begin
    logic [4:0] hw;
    int f0;
    rst_n = 1'b0; req_valid = 1'b0; updated = 1'b0; addr = '0;
    model_reset();
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_ready",  32'(req_ready),     32'd1);
    check("rst_find",   32'(find_start),    32'd0);
    check("rst_hw",     32'(hit_way),       32'd0);
    check("rst_msb",    32'(msb_index),     32'd0);
    check("rst_hits",   32'(l1_hit_count),  32'd0);
    check("rst_misses", 32'(l1_miss_count), 32'd0);

    // Cold miss, then repeat hits at distance 0
    do_access(32'h0000_1230, 0, 0, 1'b0, 1'b0, hw);
    check("cold_hw",  32'(hw), 32'd16);
    check("cold_msb", 32'(msb_index), 32'h123);
    do_access(32'h0000_1230, 0, 0, 1'b0, 1'b0, hw);
    check("repeat_hw",   32'(hw), 32'd0);
    check("repeat_hits", 32'(l1_hit_count), 32'd1);

    // A,B,C,A in set 5
    do_access(mk(1, 5), 0, 0, 1'b0, 1'b0, hw);
    do_access(mk(2, 5), 1, 0, 1'b0, 1'b1, hw);
    do_access(mk(3, 5), 0, 1, 1'b1, 1'b0, hw);
    do_access(mk(1, 5), 0, 0, 1'b0, 1'b0, hw);
    check("abca_hw", 32'(hw), 32'd2);
    check("order0", 32'(mtag[5][0]), 32'd1);
    check("order1", 32'(mtag[5][1]), 32'd3);
    check("order2", 32'(mtag[5][2]), 32'd2);
    do_access(mk(2, 5), 0, 0, 1'b0, 1'b0, hw);
    check("b_at_2", 32'(hw), 32'd2);

    // Capacity: 17 tags evict the first; second tag sits at the bottom
    for (int i = 0; i < 17; i++) do_access(mk(100 + i, 7), 0, 0, 1'b0, 1'b0, hw);
    do_access(mk(100, 7), 0, 0, 1'b0, 1'b0, hw);
    check("evicted_hw", 32'(hw), 32'd16);
    for (int i = 0; i < 17; i++) do_access(mk(200 + i, 8), 0, 0, 1'b0, 1'b0, hw);
    do_access(mk(201, 8), 0, 0, 1'b0, 1'b0, hw);
    check("bottom_hw", 32'(hw), 32'd15);

    // Slow L2: updated after 7 cycles
    f0 = fs_cnt;
    do_access(mk(1, 5), 7, 0, 1'b1, 1'b1, hw);
    check("slow_fs_once", 32'(fs_cnt - f0), 32'd1);
    check("slow_hw", 32'(hw), 32'd1);

    // updated seen in IDLE is ignored
    f0 = fs_cnt;
    updated = 1'b1; step(); step();
    updated = 1'b0; step();
    check("idle_upd_no_fs", 32'(fs_cnt - f0), 32'd0);

    // updated held high: no second start before it drops
    f0 = fs_cnt;
    do_access(mk(9, 3), 0, 4, 1'b1, 1'b0, hw);
    step(); step();
    check("held_upd_fs_once", 32'(fs_cnt - f0), 32'd1);
    check("held_upd_hw", 32'(hw), 32'd16);

    // Reset while waiting for L2
    req_valid = 1'b1; addr = 32'h0000_1230;
    step();
    req_valid = 1'b0; exp_ready = 1'b0; exp_msb = 10'h123;
    step();
    exp_find = 1'b1; exp_hw = 5'd0; exp_hits++;
    step();
    exp_find = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("mid_rst_ready", 32'(req_ready),     32'd1);
    check("mid_rst_find",  32'(find_start),    32'd0);
    check("mid_rst_hw",    32'(hit_way),       32'd0);
    check("mid_rst_msb",   32'(msb_index),     32'd0);
    check("mid_rst_hits",  32'(l1_hit_count),  32'd0);
    check("mid_rst_miss",  32'(l1_miss_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_access(32'h0000_1230, 0, 0, 1'b0, 1'b0, hw);
    check("post_rst_hw",   32'(hw), 32'd16);
    check("post_rst_miss", 32'(l1_miss_count), 32'd1);
    check("post_rst_hits", 32'(l1_hit_count),  32'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
